net_gen: RTL
============

# net_gen

Parametrised centre-net generator for the video path; successor to the fixed one-pixel, 4V-dashed net. It has its own pixel-column counter and a line-based dash sequencer. It produces a registered NET video bit with configurable column, width, dash on/off lengths and a runtime mode, including an optional frame-scrolling dash used in attract mode. It sits beside the score and paddle generators and feeds the video mixer.

## Interface
- H_POS, 256: first pixel column of the net, counted from 0 at HRESET.
- NET_WIDTH, 1: net width in pixels, at least 1.
- DASH_ON, 4: lines lit per dash period, at least 1.
- DASH_OFF, 4: lines dark per dash period, at least 0.
- CW, 9: column counter width; H_POS+NET_WIDTH ≤ 2^CW-1.
- CLK_DRV in 1: the single clock; all state is on its rising edge.
- CLR_N in 1: reset, asynchronous and active-low.
- CLK_EN in 1: pixel advance strobe; all inputs below are sampled only when CLK_EN=1.
- HRESET in 1: line start; the pixel with HRESET is column 0.
- VRESET in 1: frame start.
- VBLANK in 1: vertical blank; forces NET low.
- MODE in 2: 00 off, 01 solid, 10 dashed, 11 scrolling dashed.
- NET out 1: net video bit, registered.

## Operation
- P = DASH_ON + DASH_OFF. Dash counter width is clog2(P), minimum 1.
- Column counter hcnt, CW bits, updates on CLK_EN:
  - HRESET=1: hcnt ← 0.
  - Otherwise: hcnt ← hcnt+1, saturating at 2^CW-1 (no wrap).
- Dash counter dcnt, 0..P-1:
  - CLK_EN & VRESET: dcnt ← phase.
  - Else CLK_EN & HRESET: dcnt ← (dcnt==P-1) ? 0 : dcnt+1.
  - VRESET wins over HRESET when both are high.
- Mode register mode_q loads MODE on CLK_EN & VRESET only. Mid-frame MODE changes take effect at the next frame.
- Phase register, 0..P-1, updates on CLK_EN & VRESET:
  - If mode_q==11 (value before this load): phase ← (phase==P-1) ? 0 : phase+1.
  - Otherwise: phase ← 0.
- dash_lit = (dcnt < DASH_ON).
- On CLK_EN, NET ← in_col & line_ok & ~VBLANK, where:
  - in_col = H_POS ≤ hcnt_next ≤ H_POS+NET_WIDTH-1.
  - line_ok is 0 for mode 00, 1 for mode 01, dash_lit for modes 10 and 11.
  - mode and dash values are the post-update ones.
- When CLK_EN=0, all registers hold.
- DASH_OFF=0 with a dashed mode behaves as solid.

## Timing
- Reset values, all zero: NET=0, hcnt=0, dcnt=0, phase=0, mode_q=00 (off).
- NET is registered. NET is high in the CLK_DRV cycles following the CLK_EN strobes that move hcnt into the window, so NET is aligned with hcnt.
- Latency from an input change to NET is one CLK_EN.
- Mode latency runs from MODE to the first frame following the next VRESET.
- Reset released mid-line: NET stays 0 until in_col is satisfied, which needs HRESET after mode is loaded. Mode stays off until the first VRESET.
- Reset asserted mid-operation clears NET immediately (asynchronous).

## Configuration
- NET_GEN_SCROLL_EN defined: mode 11 scrolls the dash pattern as described. The phase register exists.
- NET_GEN_SCROLL_EN undefined: mode 11 behaves exactly as mode 10. The phase register is removed and dcnt loads 0 on VRESET.

## Structure
- Shared package net_pkg holds:
  - typedef enum logic [1:0] net_mode_t: NET_OFF, NET_SOLID, NET_DASH, NET_SCROLL.
  - Parameter default constants.
- Sub-module net_dash_ctr contains dcnt, phase and mode_q, and outputs dash_lit and mode.
- net_gen contains hcnt, the column compare and the NET register.

## Test plan
- Solid mode:
  - Stimulus: defaults, MODE=01, 512-pixel lines with HRESET, VBLANK=0.
  - Required: NET high only while hcnt=256, exactly one CLK_EN per line, every line.
- Dashed mode:
  - Stimulus: MODE=10, DASH_ON=4, DASH_OFF=4.
  - Required: lines 0–3 lit, lines 4–7 dark, repeating; restarts at lit line 0 after each VRESET.
- Width and VBLANK:
  - Stimulus: NET_WIDTH=3, H_POS=10, MODE=01, VBLANK=1 on lines 5–6.
  - Required: NET high for columns 10–12; NET low on lines 5–6.
- Scrolling with the macro:
  - Stimulus: MODE=11 with NET_GEN_SCROLL_EN, P=8.
  - Required: frame n line 0 uses dcnt = n mod 8, so the first dark line moves up by one each frame; wraps after frame 7.
  - Without the macro: identical to mode 10.
- Simultaneous strobes and mid-frame mode change:
  - Stimulus: HRESET and VRESET in the same CLK_EN; MODE changes 01→00 mid-frame.
  - Required: dcnt=phase (not incremented); the net persists until the next VRESET, then goes off.
- Reset mid-line:
  - Stimulus: CLR_N pulsed low while NET=1.
  - Required: NET=0 immediately; NET stays 0 until VRESET loads a non-off MODE and the column window is reached.

Source files
------------

// File: rtl/net_pkg.sv
// Shared types and default constants for the centre-net generator.
package net_pkg;

    typedef enum logic [1:0] {
        NET_OFF    = 2'b00,
        NET_SOLID  = 2'b01,
        NET_DASH   = 2'b10,
        NET_SCROLL = 2'b11
    } net_mode_t;

    localparam int NET_H_POS_DEF     = 256;
    localparam int NET_WIDTH_DEF     = 1;
    localparam int NET_DASH_ON_DEF   = 4;
    localparam int NET_DASH_OFF_DEF  = 4;
    localparam int NET_CW_DEF        = 9;

    // Dash counter width: enough bits for 0..period-1, never fewer than one.
    function automatic int dash_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/net_dash_ctr.sv
// Line-based dash sequencer with frame-latched mode.
// NET_GEN_SCROLL_EN adds the per-frame phase register used by the scrolling mode.
module net_dash_ctr
    import net_pkg::*;
#(
    parameter int DASH_ON  = NET_DASH_ON_DEF,
    parameter int DASH_OFF = NET_DASH_OFF_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       hreset,
    input  logic       vreset,
    input  logic [1:0] mode_in,
    output net_mode_t  mode,
    output logic       dash_lit
);

    localparam int P  = DASH_ON + DASH_OFF;
    localparam int DW = dash_width(P);
    localparam logic [DW-1:0] LAST = DW'(P - 1);
    localparam logic [DW:0]   ON_W = (DW + 1)'(DASH_ON);

    net_mode_t     mode_q;
    net_mode_t     mode_d;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_d;
    logic [DW-1:0] load_val;

`ifdef NET_GEN_SCROLL_EN
    logic [DW-1:0] phase;
    logic [DW-1:0] phase_d;

    // The phase advances only while the frame just ending was a scrolling frame.
    always_comb begin
        phase_d = phase;
        if (clk_en && vreset) begin
            if (mode_q == NET_SCROLL)
                phase_d = (phase == LAST) ? '0 : phase + 1'b1;
            else
                phase_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= '0;
        else
            phase <= phase_d;
    end

    assign load_val = phase;
`else
    assign load_val = '0;
`endif

    // VRESET takes priority over HRESET on the same strobe.
    always_comb begin
        dcnt_d = dcnt;
        mode_d = mode_q;
        if (clk_en) begin
            if (vreset) begin
                dcnt_d = load_val;
                mode_d = net_mode_t'(mode_in);
            end else if (hreset) begin
                dcnt_d = (dcnt == LAST) ? '0 : dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt   <= '0;
            mode_q <= NET_OFF;
        end else begin
            dcnt   <= dcnt_d;
            mode_q <= mode_d;
        end
    end

    assign mode     = mode_d;
    assign dash_lit = ({1'b0, dcnt_d} < ON_W);

endmodule

// File: rtl/net_gen.sv
// Parametrised centre-net generator: column counter, window compare and registered NET bit.
// Build with NET_GEN_SCROLL_EN to enable the frame-scrolling dash in mode 11.
module net_gen
    import net_pkg::*;
#(
    parameter int H_POS     = NET_H_POS_DEF,
    parameter int NET_WIDTH = NET_WIDTH_DEF,
    parameter int DASH_ON   = NET_DASH_ON_DEF,
    parameter int DASH_OFF  = NET_DASH_OFF_DEF,
    parameter int CW        = NET_CW_DEF
) (
    input  logic       CLK_DRV,
    input  logic       CLR_N,
    input  logic       CLK_EN,
    input  logic       HRESET,
    input  logic       VRESET,
    input  logic       VBLANK,
    input  logic [1:0] MODE,
    output logic       NET
);

    localparam logic [CW-1:0] COL_LO = CW'(H_POS);
    localparam logic [CW-1:0] COL_HI = CW'(H_POS + NET_WIDTH - 1);

    logic [CW-1:0] hcnt;
    logic [CW-1:0] hcnt_d;
    net_mode_t     frame_mode;
    logic          dash_lit;
    logic          line_ok;
    logic          in_col;

    net_dash_ctr #(
        .DASH_ON  (DASH_ON),
        .DASH_OFF (DASH_OFF)
    ) u_dash (
        .clk      (CLK_DRV),
        .rst_n    (CLR_N),
        .clk_en   (CLK_EN),
        .hreset   (HRESET),
        .vreset   (VRESET),
        .mode_in  (MODE),
        .mode     (frame_mode),
        .dash_lit (dash_lit)
    );

    // Saturate rather than wrap so an over-long line cannot hit the window twice.
    always_comb begin
        if (HRESET)
            hcnt_d = '0;
        else if (hcnt == '1)
            hcnt_d = hcnt;
        else
            hcnt_d = hcnt + 1'b1;
    end

    assign in_col = (hcnt_d >= COL_LO) && (hcnt_d <= COL_HI);

    always_comb begin
        line_ok = 1'b0;
        case (frame_mode)
            NET_OFF:   line_ok = 1'b0;
            NET_SOLID: line_ok = 1'b1;
            default:   line_ok = dash_lit;
        endcase
    end

    always_ff @(posedge CLK_DRV or negedge CLR_N) begin
        if (!CLR_N) begin
            hcnt <= '0;
            NET  <= 1'b0;
        end else if (CLK_EN) begin
            hcnt <= hcnt_d;
            NET  <= in_col & line_ok & ~VBLANK;
        end
    end

endmodule
